spgd_step_sequencer: RTL and testbench

Sequences one or more SPGD iterations by stepping the perturbation DAC and metric ADC through fixed phases: apply +δ, settle, sample, apply −δ, settle, sample, update. Settle and sample windows are programmable cycle counts timed by one reloadable delay timer. The block sits between the host control registers and the perturbation/metric/update datapath. It replaces ad-hoc free-running enable counters with a single scheduler that owns all phase strobes.

---
 rtl/spgd_pkg.sv | 19 +
 rtl/spgd_delay_timer.sv | 30 +++
 rtl/spgd_step_sequencer.sv | 172 +++++++++++++++++
 tb/tb_spgd_step_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spgd_pkg.sv
// Shared types and default widths for the SPGD step sequencer.
package spgd_pkg;

    localparam int unsigned SPGD_CNT_W  = 16;
    localparam int unsigned SPGD_ITER_W = 16;

    // Phase states of one SPGD iteration
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_APPLY_P  = 3'd1,
        ST_SETTLE_P = 3'd2,
        ST_SAMPLE_P = 3'd3,
        ST_APPLY_N  = 3'd4,
        ST_SETTLE_N = 3'd5,
        ST_SAMPLE_N = 3'd6,
        ST_UPDATE   = 3'd7
    } spgd_seq_state_t;

endpackage

// File: rtl/spgd_delay_timer.sv
// Reloadable down-counter: a load of N yields a window of max(N,1) cycles,
// with expire high on the last cycle of the window (and whenever idle at 0).
module spgd_delay_timer
    import spgd_pkg::*;
#(
    parameter int unsigned CNT_W = SPGD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;

    // Load N-1 (saturating at 0), otherwise count down to 0 and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= (value == '0) ? '0 : value - CNT_W'(1);
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/spgd_step_sequencer.sv
// Scheduler owning all SPGD phase strobes: +delta, settle, sample,
// -delta, settle, sample, update; repeated n_iter times or until abort.
module spgd_step_sequencer
    import spgd_pkg::*;
#(
    parameter int unsigned CNT_W  = SPGD_CNT_W,
    parameter int unsigned ITER_W = SPGD_ITER_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  settle_cycles,
    input  logic [CNT_W-1:0]  sample_cycles,
    input  logic [ITER_W-1:0] n_iter,
    output logic              pert_sign,
    output logic              dac_load,
    output logic              adc_sample_en,
    output logic              metric_p_latch,
    output logic              metric_n_latch,
    output logic              update_en,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt
);

    spgd_seq_state_t   state_q, state_d;

    logic [CNT_W-1:0]  settle_sh_q;
    logic [CNT_W-1:0]  sample_sh_q;
    logic [ITER_W-1:0] n_iter_sh_q;
    logic [ITER_W-1:0] iter_cnt_q;
    logic [ITER_W-1:0] iter_inc;
    logic              done_q;

    logic              accept;
    logic              last_iter;
    logic              timer_load;
    logic [CNT_W-1:0]  timer_value;
    logic              timer_expire;

    // Run acceptance and end-of-run detection
    always_comb begin
        accept    = (state_q == ST_IDLE) && start && !abort;
        iter_inc  = iter_cnt_q + ITER_W'(1);
        last_iter = (n_iter_sh_q != '0) && (iter_inc == n_iter_sh_q);
    end

    // Single timer shared by all settle and sample windows
    spgd_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .value  (timer_value),
        .expire (timer_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, timer reload and phase-strobe decode
    always_comb begin
        state_d        = state_q;
        timer_load     = 1'b0;
        timer_value    = '0;
        pert_sign      = 1'b0;
        dac_load       = 1'b0;
        adc_sample_en  = 1'b0;
        metric_p_latch = 1'b0;
        metric_n_latch = 1'b0;
        update_en      = 1'b0;
        busy           = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_APPLY_P;
                end
            end
            ST_APPLY_P: begin
                dac_load    = 1'b1;
                timer_load  = 1'b1;
                timer_value = settle_sh_q;
                state_d     = ST_SETTLE_P;
            end
            ST_SETTLE_P: begin
                if (timer_expire) begin
                    timer_load  = 1'b1;
                    timer_value = sample_sh_q;
                    state_d     = ST_SAMPLE_P;
                end
            end
            ST_SAMPLE_P: begin
                adc_sample_en = 1'b1;
                if (timer_expire) begin
                    metric_p_latch = 1'b1;
                    state_d        = ST_APPLY_N;
                end
            end
            ST_APPLY_N: begin
                pert_sign   = 1'b1;
                dac_load    = 1'b1;
                timer_load  = 1'b1;
                timer_value = settle_sh_q;
                state_d     = ST_SETTLE_N;
            end
            ST_SETTLE_N: begin
                pert_sign = 1'b1;
                if (timer_expire) begin
                    timer_load  = 1'b1;
                    timer_value = sample_sh_q;
                    state_d     = ST_SAMPLE_N;
                end
            end
            ST_SAMPLE_N: begin
                pert_sign     = 1'b1;
                adc_sample_en = 1'b1;
                if (timer_expire) begin
                    metric_n_latch = 1'b1;
                    state_d        = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                update_en = 1'b1;
                state_d   = last_iter ? ST_IDLE : ST_APPLY_P;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides any transition out of a busy state
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            timer_load = 1'b0;
        end
    end

    // Shadow configuration, iteration counter and done strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_sh_q <= '0;
            sample_sh_q <= '0;
            n_iter_sh_q <= '0;
            iter_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                settle_sh_q <= settle_cycles;
                sample_sh_q <= sample_cycles;
                n_iter_sh_q <= n_iter;
                iter_cnt_q  <= '0;
            end else if ((state_q == ST_UPDATE) && !abort) begin
                iter_cnt_q <= iter_inc;
                done_q     <= last_iter;
            end
        end
    end

    assign done     = done_q;
    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_spgd_step_sequencer.sv
// Scoreboard bench: per-cycle expected strobe vectors are derived from the
// window lengths when a run is launched, then compared cycle by cycle.
module tb_spgd_step_sequencer;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ITER_W = 16;

    localparam logic [7:0] B_SIGN = 8'h80;
    localparam logic [7:0] B_DAC  = 8'h40;
    localparam logic [7:0] B_ADC  = 8'h20;
    localparam logic [7:0] B_P    = 8'h10;
    localparam logic [7:0] B_N    = 8'h08;
    localparam logic [7:0] B_UPD  = 8'h04;
    localparam logic [7:0] B_BUSY = 8'h02;
    localparam logic [7:0] B_DONE = 8'h01;

    typedef struct packed {
        logic [7:0]  sig;
        logic [7:0]  mask;
        logic [15:0] cnt;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  settle_cycles;
    logic [CNT_W-1:0]  sample_cycles;
    logic [ITER_W-1:0] n_iter;
    logic              pert_sign;
    logic              dac_load;
    logic              adc_sample_en;
    logic              metric_p_latch;
    logic              metric_n_latch;
    logic              update_en;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_cnt;
    logic [7:0]        obs_sig;

    int    n_checks;
    int    n_errors;
    string cur_test;
    exp_t  sb[$];

    spgd_step_sequencer #(
        .CNT_W  (CNT_W),
        .ITER_W (ITER_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .settle_cycles  (settle_cycles),
        .sample_cycles  (sample_cycles),
        .n_iter         (n_iter),
        .pert_sign      (pert_sign),
        .dac_load       (dac_load),
        .adc_sample_en  (adc_sample_en),
        .metric_p_latch (metric_p_latch),
        .metric_n_latch (metric_n_latch),
        .update_en      (update_en),
        .busy           (busy),
        .done           (done),
        .iter_cnt       (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_sig = {pert_sign, dac_load, adc_sample_en, metric_p_latch,
                      metric_n_latch, update_en, busy, done};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", cur_test, tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] sig, input logic [7:0] mask, input logic [15:0] cnt);
        exp_t e;
        e.sig  = sig;
        e.mask = mask;
        e.cnt  = cnt;
        return e;
    endfunction

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Push the first lim cycles (all if lim < 0) of iteration idx
    task automatic push_iter(input int s, input int m, input int idx, input int lim);
        exp_t tmp[$];
        logic [15:0] c;
        c = 16'(idx);
        tmp.push_back(mk(B_DAC | B_BUSY, 8'hFF, c));
        for (int k = 0; k < s; k++) tmp.push_back(mk(B_BUSY, 8'hFF, c));
        for (int k = 0; k < m; k++)
            tmp.push_back(mk(B_ADC | B_BUSY | ((k == m - 1) ? B_P : 8'h00), 8'hFF, c));
        tmp.push_back(mk(B_SIGN | B_DAC | B_BUSY, 8'hFF, c));
        for (int k = 0; k < s; k++) tmp.push_back(mk(B_SIGN | B_BUSY, 8'hFF, c));
        for (int k = 0; k < m; k++)
            tmp.push_back(mk(B_SIGN | B_ADC | B_BUSY | ((k == m - 1) ? B_N : 8'h00), 8'hFF, c));
        tmp.push_back(mk(B_UPD | B_BUSY, 8'h7F, c));
        for (int k = 0; k < tmp.size() && (lim < 0 || k < lim); k++) sb.push_back(tmp[k]);
    endtask

    task automatic push_idle(input int ncyc, input int cnt);
        for (int k = 0; k < ncyc; k++) sb.push_back(mk(8'h00, 8'hFF, 16'(cnt)));
    endtask

    task automatic push_run(input int settle, input int sample, input int n);
        for (int i = 0; i < n; i++) push_iter(eff(settle), eff(sample), i, -1);
        sb.push_back(mk(B_DONE, 8'hFF, 16'(n)));
        push_idle(1, n);
    endtask

    // Present a start for one edge; caller sits #1 after an edge
    task automatic launch(input int settle, input int sample, input int n);
        settle_cycles = CNT_W'(settle);
        sample_cycles = CNT_W'(sample);
        n_iter        = ITER_W'(n);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Pop and compare one entry per cycle; optional input disturbance while busy
    task automatic drain(input bit disturb, input bit abort_at_end);
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check("sig", 32'(obs_sig & e.mask), 32'(e.sig & e.mask));
            check("iter_cnt", 32'(iter_cnt), 32'(e.cnt));
            if (disturb && ((e.sig & B_BUSY) != 8'h00)) begin
                start         = 1'($urandom_range(0, 1));
                settle_cycles = CNT_W'(9);
                sample_cycles = CNT_W'($urandom_range(0, 20));
                n_iter        = ITER_W'($urandom_range(0, 5));
            end else begin
                start = 1'b0;
            end
            if (abort_at_end && sb.size() == 0) abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cur_test      = "reset";
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        settle_cycles = '0;
        sample_cycles = '0;
        n_iter        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sig", 32'(obs_sig), 32'h0);
        check("rst_cnt", 32'(iter_cnt), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cur_test = "idle";
        push_idle(20, 0);
        drain(1'b0, 1'b0);

        cur_test = "single";
        launch(3, 2, 1);
        push_run(3, 2, 1);
        drain(1'b0, 1'b0);

        cur_test = "zero_len";
        launch(0, 0, 2);
        push_run(0, 0, 2);
        drain(1'b0, 1'b0);

        // Continuous run aborted in the first SETTLE_N cycle of iteration 3
        cur_test = "abort";
        launch(2, 1, 0);
        push_iter(2, 1, 0, -1);
        push_iter(2, 1, 1, -1);
        push_iter(2, 1, 2, 6);
        drain(1'b0, 1'b1);
        push_idle(3, 2);
        drain(1'b0, 1'b0);

        cur_test = "abort_start_idle";
        settle_cycles = CNT_W'(1);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        push_idle(3, 2);
        drain(1'b0, 1'b0);

        cur_test = "cfg_isolation";
        launch(3, 2, 2);
        push_run(3, 2, 2);
        drain(1'b1, 1'b0);

        cur_test = "cfg_reload";
        launch(9, 2, 1);
        push_run(9, 2, 1);
        drain(1'b0, 1'b0);

        // Async reset while in the first SAMPLE_P cycle
        cur_test = "async_rst";
        launch(3, 2, 1);
        push_iter(3, 2, 0, 4);
        drain(1'b0, 1'b0);
        check("pre_rst", 32'(obs_sig), 32'(B_ADC | B_BUSY));
        rst_n = 1'b0;
        #1;
        check("in_rst_sig", 32'(obs_sig), 32'h0);
        check("in_rst_cnt", 32'(iter_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_idle(20, 0);
        drain(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
